// File: rtl/tartaruga_pkg.sv
// Shared types and constants for the tartaruga core front end.
// Holds the fetch FSM state encoding, the buffered fetch entry and the default boot address.
package tartaruga_pkg;

    typedef logic [31:0] bus32_t;

    localparam bus32_t      RESET_VECTOR_DEFAULT    = 32'h0000_0000;
    localparam int unsigned FETCH_BUF_DEPTH_DEFAULT = 2;
    localparam bus32_t      INSTR_BYTES             = 32'd4;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        bus32_t pc;
        bus32_t instr;
    } fetch_entry_t;

    function automatic logic is_word_aligned(input bus32_t addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs between fetch and decode.
// Flush empties it in one cycle; pointers wrap explicitly so any depth >= 2 works.
module fetch_buffer
    import tartaruga_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_BUF_DEPTH_DEFAULT
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           push_i,
    input  fetch_entry_t                   push_data_i,
    input  logic                           pop_i,
    output fetch_entry_t                   head_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;
    logic             wr_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[head_q];

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        wr_en   = 1'b0;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                wr_en  = 1'b1;
                tail_d = ptr_inc(tail_q);
            end
            if (pop_ok) begin
                head_d = ptr_inc(head_q);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; an empty count already hides stale contents.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the PC, captures instructions into a small buffer
// and presents them to decode with a valid/ready handshake, honouring redirect and halt.
module fetch_ctrl
    import tartaruga_pkg::*;
#(
    parameter logic [31:0]  RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int unsigned  BUF_DEPTH    = FETCH_BUF_DEPTH_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] pc_o,
    input  logic [31:0] instr_i,
    output logic        fetch_valid_o,
    input  logic        fetch_ready_i,
    output logic [31:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    output logic        misalign_o
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_t     state_q;
    logic [31:0]      pc_q, pc_d;
    logic             misalign_q;

    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;
    logic             buf_full;
    logic             buf_empty;
    logic [CNT_W-1:0] buf_count;
    logic             push;
    logic             pop;
    logic             unused_buf_empty;

    // A redirect squashes any handshake in the same cycle; the flush removes the entry anyway.
    assign pop  = fetch_valid_o && fetch_ready_i && !redirect_i;
    assign push = (state_q == RUN) && !redirect_i && !halt_i && (!buf_full || pop);

    assign pc_d       = pc_q + INSTR_BYTES;
    assign push_entry = '{pc: pc_q, instr: instr_i};

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (redirect_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head_entry),
        .full_o      (buf_full),
        .empty_o     (buf_empty),
        .count_o     (buf_count)
    );

    assign unused_buf_empty = buf_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else if (redirect_i) begin
            // A misaligned target keeps the old PC and parks the fetcher until a good redirect.
            if (is_word_aligned(redirect_pc_i)) begin
                pc_q       <= redirect_pc_i;
                misalign_q <= 1'b0;
                state_q    <= RUN;
            end else begin
                misalign_q <= 1'b1;
                state_q    <= HALTED;
            end
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= RUN;
                end
                RUN: begin
                    if (halt_i) begin
                        state_q <= HALTED;
                    end
                    if (push) begin
                        pc_q <= pc_d;
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

    assign pc_o          = pc_q;
    assign fetch_valid_o = (buf_count != '0);
    assign fetch_instr_o = head_entry.instr;
    assign fetch_pc_o    = head_entry.pc;
    assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: scenario tasks drive stimulus, a queue holds the
// expected pc stream and every decode handshake is compared against its front.
module tb_fetch_ctrl;
    import tartaruga_pkg::*;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_o;
    logic [31:0] instr_i;
    logic        fetch_valid_o;
    logic        fetch_ready_i;
    logic [31:0] fetch_instr_o;
    logic [31:0] fetch_pc_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        halt_i;
    logic        misalign_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    fetch_ctrl #(
        .RESET_VECTOR (RV),
        .BUF_DEPTH    (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .pc_o          (pc_o),
        .instr_i       (instr_i),
        .fetch_valid_o (fetch_valid_o),
        .fetch_ready_i (fetch_ready_i),
        .fetch_instr_o (fetch_instr_o),
        .fetch_pc_o    (fetch_pc_o),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .misalign_o    (misalign_o)
    );

    function automatic logic [31:0] imem(input logic [31:0] addr);
        case (addr)
            32'h0:   return 32'h4567_90b7;
            32'h4:   return 32'h9010_8093;
            32'h8:   return 32'hFFF0_8193;
            32'hC:   return 32'h0000_4237;
            default: return {addr[15:0], ~addr[15:0]};
        endcase
    endfunction

    assign instr_i = imem(pc_o);

    // Scores a handshake about to complete at the next edge, then advances one cycle.
    task automatic tick();
        if (!rst_i && !redirect_i && fetch_valid_o && fetch_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got pc %h, required no handshake", fetch_pc_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                checks++;
                if (fetch_pc_o !== e) begin
                    errors++;
                    $display("FAIL pop_pc: got %h, required %h", fetch_pc_o, e);
                end
                checks++;
                if (fetch_instr_o !== imem(e)) begin
                    errors++;
                    $display("FAIL pop_instr: got %h, required %h", fetch_instr_o, imem(e));
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_i    = 1'b1;
        redirect_pc_i = target;
        tick();
        redirect_i    = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; halt_i = 1'b0; fetch_ready_i = 1'b0;
        tick();
        tick();
        checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", fetch_valid_o); end
        checks++; if (pc_o !== RV) begin errors++; $display("FAIL reset_pc: got %h, required %h", pc_o, RV); end
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b, required 0", misalign_o); end
    endtask

    task automatic test_boot();
        exp_q.delete();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        fetch_ready_i = 1'b1;
        rst_i = 1'b0;
        checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL boot_c0_valid: got %b, required 0", fetch_valid_o); end
        tick();
        checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL boot_c1_valid: got %b, required 0", fetch_valid_o); end
        tick();
        checks++; if (fetch_valid_o !== 1'b1) begin errors++; $display("FAIL boot_c2_valid: got %b, required 1", fetch_valid_o); end
        checks++; if (fetch_pc_o !== 32'h0) begin errors++; $display("FAIL boot_c2_pc: got %h, required 0", fetch_pc_o); end
        checks++; if (fetch_instr_o !== 32'h4567_90b7) begin errors++; $display("FAIL boot_c2_instr: got %h, required 456790b7", fetch_instr_o); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (fetch_valid_o !== 1'b1) begin errors++; $display("FAIL boot_stream_valid: cycle %0d got %b, required 1", i, fetch_valid_o); end
            tick();
        end
        fetch_ready_i = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL boot_drain: %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        fetch_ready_i = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) tick();
        checks++; if (fetch_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b, required 1", fetch_valid_o); end
        checks++; if (pc_o !== 32'h8) begin errors++; $display("FAIL bp_pc_o: got %h, required 8", pc_o); end
        checks++; if (fetch_pc_o !== 32'h0) begin errors++; $display("FAIL bp_head_pc: got %h, required 0", fetch_pc_o); end
        checks++; if (fetch_instr_o !== imem(32'h0)) begin errors++; $display("FAIL bp_head_instr: got %h, required %h", fetch_instr_o, imem(32'h0)); end
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        fetch_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (fetch_valid_o !== 1'b1) begin errors++; $display("FAIL bp_release_valid: cycle %0d got %b, required 1", i, fetch_valid_o); end
            tick();
        end
        fetch_ready_i = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_redirect();
        exp_q.delete();
        fetch_ready_i = 1'b1;
        redirect_to(32'h40);
        checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b, required 0", fetch_valid_o); end
        checks++; if (pc_o !== 32'h40) begin errors++; $display("FAIL redir_pc_o: got %h, required 40", pc_o); end
        exp_q.push_back(32'h40); exp_q.push_back(32'h44);
        tick();
        checks++; if (fetch_valid_o !== 1'b1) begin errors++; $display("FAIL redir_head_valid: got %b, required 1", fetch_valid_o); end
        checks++; if (fetch_pc_o !== 32'h40) begin errors++; $display("FAIL redir_head_pc: got %h, required 40", fetch_pc_o); end
        tick();
        tick();
        fetch_ready_i = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL redir_drain: %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_priority();
        exp_q.delete();
        fetch_ready_i = 1'b0;
        halt_i = 1'b1;
        redirect_to(32'h200);
        halt_i = 1'b0;
        checks++; if (pc_o !== 32'h200) begin errors++; $display("FAIL prio_pc_o: got %h, required 200", pc_o); end
        checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL prio_valid: got %b, required 0", fetch_valid_o); end
        tick();
        checks++; if (fetch_valid_o !== 1'b1) begin errors++; $display("FAIL prio_run_valid: got %b, required 1", fetch_valid_o); end
        checks++; if (fetch_pc_o !== 32'h200) begin errors++; $display("FAIL prio_run_pc: got %h, required 200", fetch_pc_o); end
    endtask

    task automatic test_misalign();
        exp_q.delete();
        fetch_ready_i = 1'b0;
        redirect_to(32'h80);
        tick();
        tick();
        redirect_to(32'h42);
        checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b, required 1", misalign_o); end
        checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL mis_valid: got %b, required 0", fetch_valid_o); end
        checks++; if (pc_o !== 32'h88) begin errors++; $display("FAIL mis_pc_o: got %h, required 88", pc_o); end
        fetch_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL mis_halted_valid: cycle %0d got %b, required 0", i, fetch_valid_o); end
            checks++; if (pc_o !== 32'h88) begin errors++; $display("FAIL mis_halted_pc: cycle %0d got %h, required 88", i, pc_o); end
        end
        exp_q.push_back(32'h10); exp_q.push_back(32'h14);
        redirect_to(32'h10);
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b, required 0", misalign_o); end
        checks++; if (pc_o !== 32'h10) begin errors++; $display("FAIL mis_resume_pc_o: got %h, required 10", pc_o); end
        tick();
        checks++; if (fetch_valid_o !== 1'b1) begin errors++; $display("FAIL mis_resume_valid: got %b, required 1", fetch_valid_o); end
        checks++; if (fetch_pc_o !== 32'h10) begin errors++; $display("FAIL mis_resume_head: got %h, required 10", fetch_pc_o); end
        tick();
        tick();
        fetch_ready_i = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mis_drain: %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_halt();
        exp_q.delete();
        fetch_ready_i = 1'b0;
        redirect_to(32'h100);
        tick();
        tick();
        halt_i = 1'b1;
        tick();
        halt_i = 1'b0;
        exp_q.push_back(32'h100); exp_q.push_back(32'h104);
        fetch_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (fetch_valid_o !== 1'b1) begin errors++; $display("FAIL halt_drain_valid: cycle %0d got %b, required 1", i, fetch_valid_o); end
            checks++; if (pc_o !== 32'h108) begin errors++; $display("FAIL halt_drain_pc_o: cycle %0d got %h, required 108", i, pc_o); end
            tick();
        end
        checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL halt_empty_valid: got %b, required 0", fetch_valid_o); end
        tick();
        tick();
        checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL halt_stay_valid: got %b, required 0", fetch_valid_o); end
        checks++; if (pc_o !== 32'h108) begin errors++; $display("FAIL halt_stay_pc_o: got %h, required 108", pc_o); end
        fetch_ready_i = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL halt_drain: %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        exp_q.delete();
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        fetch_ready_i = 1'b1;
        redirect_to(32'hFFFF_FFFC);
        checks++; if (pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc_o: got %h, required fffffffc", pc_o); end
        tick();
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL wrap_next_pc_o: got %h, required 0", pc_o); end
        checks++; if (fetch_pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_head: got %h, required fffffffc", fetch_pc_o); end
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        fetch_ready_i = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_timeout: %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_midstream_reset();
        exp_q.delete();
        fetch_ready_i = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (fetch_valid_o !== 1'b1) begin errors++; $display("FAIL mrst_pre_valid: got %b, required 1", fetch_valid_o); end
        rst_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h300; halt_i = 1'b1;
        tick();
        checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b, required 0", fetch_valid_o); end
        checks++; if (pc_o !== RV) begin errors++; $display("FAIL mrst_pc_o: got %h, required %h", pc_o, RV); end
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mrst_misalign: got %b, required 0", misalign_o); end
        rst_i = 1'b0; redirect_i = 1'b0; halt_i = 1'b0;
        tick();
        checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL mrst_boot_valid: got %b, required 0", fetch_valid_o); end
        tick();
        checks++; if (fetch_valid_o !== 1'b1) begin errors++; $display("FAIL mrst_run_valid: got %b, required 1", fetch_valid_o); end
        checks++; if (fetch_pc_o !== RV) begin errors++; $display("FAIL mrst_run_head: got %h, required %h", fetch_pc_o, RV); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_boot();
        test_backpressure();
        test_redirect();
        test_priority();
        test_misalign();
        test_halt();
        test_wrap();
        test_midstream_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
